keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 61 ++++++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key encoding for the 4x4 keypad scanner and its consumers.
// Direction codes are the values game_control expects on key_in.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_DOWN  = 4'h8;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;

    // Rows top-to-bottom, columns left-to-right; '*' encodes as E and '#' as F.
    function automatic logic [3:0] map_key(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = KEY_UP;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = KEY_LEFT;
            4'h5: code = 4'h5;
            4'h6: code = KEY_RIGHT;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = KEY_DOWN;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
module sync_2ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk_50MHz_i,
    input  logic              rst_async_la_i,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, hex encode, one strobe per press.
// Optional auto-repeat while held is built when KEYPAD_REPEAT_EN is defined.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_SCAN     | rotate the driven column, sample rows at end of each dwell
//   ST_DEBOUNCE | column frozen, latched row pattern must stay stable
//   ST_HELD     | key accepted, waiting for all rows to go high
//   ST_RELEASE  | rows all high, must stay high for the debounce time
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic        clk_50MHz_i,
    input  logic        rst_async_la_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o,
    output logic        key_held_o
);

    localparam int DW = (SCAN_DIV > 2)        ? $clog2(SCAN_DIV)        : 1;
    localparam int SW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] DEB_LAST = SW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("keypad_scanner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    kp_state_e        state, state_nx;
    logic [3:0]       row_s;
    logic [3:0]       row_lat;
    logic [1:0]       col_idx;
    logic [DW-1:0]    div_cnt;
    logic [SW-1:0]    stab_cnt;

    logic div_clr, col_adv, stab_clr, row_latch, accept, release_done, rep_strobe;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk_50MHz_i    (clk_50MHz_i),
        .rst_async_la_i (rst_async_la_i),
        .d              (row_i),
        .q              (row_s)
    );

    assign col_o = ~(4'b0001 << col_idx);

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
`endif

    always_comb begin
        state_nx     = state;
        div_clr      = 1'b0;
        col_adv      = 1'b0;
        stab_clr     = 1'b0;
        row_latch    = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        rep_strobe   = 1'b0;
        case (state)
            ST_SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    // Zero or several low rows are ghosting/no-key: keep scanning.
                    if (single_low(row_s)) begin
                        row_latch = 1'b1;
                        stab_clr  = 1'b1;
                        state_nx  = ST_DEBOUNCE;
                    end else begin
                        col_adv = 1'b1;
                        div_clr = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (row_s != row_lat) begin
                    col_adv  = 1'b1;
                    div_clr  = 1'b1;
                    state_nx = ST_SCAN;
                end else if (stab_cnt == DEB_LAST) begin
                    accept   = 1'b1;
                    state_nx = ST_HELD;
                end
            end
            ST_HELD: begin
                if (row_s == 4'hF) begin
                    stab_clr = 1'b1;
                    state_nx = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    rep_strobe = 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                if (row_s != 4'hF) begin
                    state_nx = ST_HELD;
                end else if (stab_cnt == DEB_LAST) begin
                    release_done = 1'b1;
                    col_adv      = 1'b1;
                    div_clr      = 1'b1;
                    state_nx     = ST_SCAN;
                end
            end
            default: state_nx = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state       <= ST_SCAN;
            div_cnt     <= '0;
            stab_cnt    <= '0;
            col_idx     <= 2'd0;
            row_lat     <= 4'hF;
            key_o       <= 4'h0;
            key_valid_o <= 1'b0;
            key_held_o  <= 1'b0;
        end else begin
            state <= state_nx;

            if (div_clr)
                div_cnt <= '0;
            else if (state == ST_SCAN && div_cnt != DIV_LAST)
                div_cnt <= div_cnt + 1'b1;

            if (col_adv)
                col_idx <= col_idx + 2'd1;

            if (row_latch)
                row_lat <= row_s;

            if (stab_clr)
                stab_cnt <= '0;
            else if ((state == ST_DEBOUNCE || state == ST_RELEASE) && stab_cnt != DEB_LAST)
                stab_cnt <= stab_cnt + 1'b1;

            key_valid_o <= accept | rep_strobe;

            if (accept)
                key_o <= map_key(row_index(row_lat), col_idx);

            if (accept)
                key_held_o <= 1'b1;
            else if (release_done)
                key_held_o <= 1'b0;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Repeat phase restarts at acceptance and simply pauses across release bounces.
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i)
            rep_cnt <= '0;
        else if (accept || rep_strobe)
            rep_cnt <= '0;
        else if (state == ST_HELD && row_s != 4'hF)
            rep_cnt <= rep_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a passive keypad-matrix model.
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int REPEAT_CYCLES   = 64;

    logic       clk_50MHz_i;
    logic       rst_async_la_i;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       key_held_o;

    logic [15:0] press_m;
    logic [3:0]  exp_q[$];
    int          n_cmp;
    int          n_err;
    int          strobe_cnt;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk_50MHz_i    (clk_50MHz_i),
        .rst_async_la_i (rst_async_la_i),
        .row_i          (row_i),
        .col_o          (col_o),
        .key_o          (key_o),
        .key_valid_o    (key_valid_o),
        .key_held_o     (key_held_o)
    );

    initial clk_50MHz_i = 1'b0;
    always #10 clk_50MHz_i = ~clk_50MHz_i;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_m[r*4+c] && !col_o[c])
                    row_i[r] = 1'b0;
    end

    always @(negedge clk_50MHz_i) begin
        if (rst_async_la_i && key_valid_o) begin
            logic [3:0] e;
            strobe_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: key_o=%h, required no strobe", key_o);
            end else begin
                e = exp_q.pop_front();
                if (key_o !== e) begin
                    n_err++;
                    $display("FAIL strobe_key: key_o=%h required %h", key_o, e);
                end
            end
            n_cmp++;
            if (key_held_o !== 1'b1) begin
                n_err++;
                $display("FAIL held_at_strobe: key_held_o=%b required 1", key_held_o);
            end
        end
    end

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[10];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50MHz_i);
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        press_m[r*4+c] = v;
    endtask

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic wait_held(input logic v, input int budget, input string nm);
        int k;
        k = 0;
        while (key_held_o !== v && k < budget) begin
            @(negedge clk_50MHz_i);
            k++;
        end
        n_cmp++;
        if (key_held_o !== v) begin
            n_err++;
            $display("FAIL %s: key_held_o=%b required %b within %0d cycles", nm, key_held_o, v, budget);
        end
    endtask

    task automatic check_queue_empty(input string nm);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected strobes missing, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [3:0] col_seq[4];
        logic       seen_other;
        int         s0;

        n_cmp = 0; n_err = 0; strobe_cnt = 0;
        press_m = '0;
        col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

        vecs[0] = '{0, 1, 4'h2};
        vecs[1] = '{1, 0, 4'h4};
        vecs[2] = '{1, 2, 4'h6};
        vecs[3] = '{2, 1, 4'h8};
        vecs[4] = '{3, 0, 4'hE};
        vecs[5] = '{3, 1, 4'h0};
        vecs[6] = '{3, 2, 4'hF};
        vecs[7] = '{3, 3, 4'hD};
        vecs[8] = '{0, 3, 4'hA};
        vecs[9] = '{2, 2, 4'h9};

        // Reset state and column rotation
        rst_async_la_i = 1'b0;
        cyc(3);
        check4("rst_col", col_o, 4'b1110);
        check4("rst_key", key_o, 4'h0);
        check4("rst_valid", {3'b0, key_valid_o}, 4'h0);
        check4("rst_held", {3'b0, key_held_o}, 4'h0);
        rst_async_la_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(2);
            check4("col_rotate", col_o, col_seq[k % 4]);
            cyc(2);
        end

        // Clean presses from the table; key_o must hold after release
        foreach (vecs[i]) begin
            set_key(vecs[i].row, vecs[i].col, 1'b1);
            exp_q.push_back(vecs[i].code);
            wait_held(1'b1, 80, "press_accept");
            cyc(40);
            check4("held_during_press", {3'b0, key_held_o}, 4'h1);
            set_key(vecs[i].row, vecs[i].col, 1'b0);
            wait_held(1'b0, 80, "release_done");
            cyc(10);
            check4("key_hold_after_release", key_o, vecs[i].code);
        end
        check_queue_empty("table_strobes");

        // Bounce on press and release of r2c1
        for (int k = 0; k < 6; k++) begin
            set_key(2, 1, (k % 2) == 0);
            cyc(5);
        end
        set_key(2, 1, 1'b1);
        exp_q.push_back(4'h8);
        wait_held(1'b1, 80, "bounce_accept");
        cyc(10);
        for (int k = 0; k < 6; k++) begin
            set_key(2, 1, (k % 2) != 0);
            cyc(5);
        end
        set_key(2, 1, 1'b0);
        wait_held(1'b0, 80, "bounce_release");
        cyc(10);
        check_queue_empty("bounce_strobes");

        // Ghosting: two rows low on column 2
        set_key(1, 2, 1'b1);
        set_key(2, 2, 1'b1);
        seen_other = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cyc(1);
            if (col_o != 4'b1011) seen_other = 1'b1;
        end
        check4("ghost_no_held", {3'b0, key_held_o}, 4'h0);
        check4("ghost_scanning", {3'b0, seen_other}, 4'h1);
        set_key(1, 2, 1'b0);
        exp_q.push_back(4'h9);
        wait_held(1'b1, 80, "ghost_resolve_accept");
        set_key(2, 2, 1'b0);
        wait_held(1'b0, 80, "ghost_resolve_release");
        cyc(10);
        check_queue_empty("ghost_strobes");

        // Second key while held is ignored until full release
        set_key(1, 2, 1'b1);
        exp_q.push_back(4'h6);
        wait_held(1'b1, 80, "first_key_accept");
        cyc(5);
        set_key(1, 0, 1'b1);
        cyc(40);
        check4("second_key_ignored", key_o, 4'h6);
        set_key(1, 2, 1'b0);
        set_key(1, 0, 1'b0);
        wait_held(1'b0, 80, "both_release");
        cyc(10);
        set_key(1, 0, 1'b1);
        exp_q.push_back(4'h4);
        wait_held(1'b1, 80, "fresh_key_accept");
        set_key(1, 0, 1'b0);
        wait_held(1'b0, 80, "fresh_key_release");
        cyc(10);
        check_queue_empty("second_key_strobes");

        // Long hold: auto-repeat only when the feature is built
        s0 = strobe_cnt;
        set_key(1, 2, 1'b1);
`ifdef KEYPAD_REPEAT_EN
        repeat (4) exp_q.push_back(4'h6);
`else
        exp_q.push_back(4'h6);
`endif
        wait_held(1'b1, 80, "repeat_accept");
        cyc(200);
        set_key(1, 2, 1'b0);
        wait_held(1'b0, 80, "repeat_release");
        cyc(10);
        n_cmp++;
`ifdef KEYPAD_REPEAT_EN
        if (strobe_cnt - s0 != 4) begin
`else
        if (strobe_cnt - s0 != 1) begin
`endif
            n_err++;
            $display("FAIL repeat_count: got %0d strobes", strobe_cnt - s0);
        end
        check_queue_empty("repeat_strobes");

        // Reset mid-hold: outputs clear at once, held key is re-detected
        set_key(0, 0, 1'b1);
        exp_q.push_back(4'h1);
        wait_held(1'b1, 80, "pre_reset_accept");
        cyc(5);
        #3 rst_async_la_i = 1'b0;
        #1;
        check4("midrst_col", col_o, 4'b1110);
        check4("midrst_key", key_o, 4'h0);
        check4("midrst_valid", {3'b0, key_valid_o}, 4'h0);
        check4("midrst_held", {3'b0, key_held_o}, 4'h0);
        cyc(2);
        rst_async_la_i = 1'b1;
        exp_q.push_back(4'h1);
        wait_held(1'b1, 80, "post_reset_accept");
        set_key(0, 0, 1'b0);
        wait_held(1'b0, 80, "post_reset_release");
        cyc(10);
        check_queue_empty("reset_strobes");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
